alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/result width; legal values 4..64, power of two.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  operand/opcode bundle valid.
REQ-005 in_ready  output  1  block accepts a bundle this cycle.
REQ-006 a, b  input  DATA_WIDTH each  operands; a is the shift source, b[$clog2(DATA_WIDTH)-1:0] the shift amount.
REQ-007 opcode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  DATA_WIDTH  registered result.
REQ-011 zero_flag, carry_flag, overflow_flag, negative_flag  output  1 each  registered flags for result.
REQ-012 illegal_op  output  1  registered; set with result when MUL issued while multiplier compiled out.

Function
REQ-013 Transfer in on in_valid && in_ready, out on out_valid && out_ready; result/flags stable while out_valid && !out_ready.
REQ-014 in_ready = (state == IDLE) && (!out_valid || out_ready), allowing back-to-back single-cycle ops at full throughput.
REQ-015 Non-MUL ops: result and out_valid registered on the accept edge (latency 1 cycle).
REQ-016 ADD: carry = bit DATA_WIDTH of a+b; overflow = signed overflow (operand signs equal, result sign differs).
REQ-017 SUB: carry = borrow (a < b unsigned); overflow = signed overflow of a-b.
REQ-018 AND/OR/XOR: carry = 0, overflow = 0.
REQ-019 SHL/SHR logical: carry = last bit shifted out, 0 when amount = 0; overflow = 0.
REQ-020 zero = (result == 0); negative = result[DATA_WIDTH-1]; both for every op.
REQ-021 MUL: FSM IDLE -> MUL_RUN (DATA_WIDTH cycles, one shift-add step per cycle) -> IDLE, loading result/out_valid on the last MUL_RUN cycle; accept-to-out_valid latency DATA_WIDTH+1 cycles.
REQ-022 MUL result = low DATA_WIDTH bits of unsigned product; overflow = (high half != 0); carry = 0.
REQ-023 During MUL_RUN in_ready = 0; a pending unconsumed result is held, never overwritten.
REQ-024 MUL completing while out_valid && !out_ready stalls in MUL_RUN final step until out_ready.
REQ-025 Operands 0, all-ones and shift amount DATA_WIDTH-1 produce arithmetically exact results with no special-casing.

Reset
REQ-026 rst asserted: state = IDLE, out_valid = 0, result = 0, all flags = 0, illegal_op = 0, multiplier accumulator cleared, immediately and asynchronously.
REQ-027 rst mid-MUL aborts the operation; no result is produced for it after release.
REQ-028 First accept possible on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro ALU_PIPE_MUL_EN defined: MUL implemented per REQ-021..024.
REQ-030 ALU_PIPE_MUL_EN undefined: no multiplier logic; MUL accepted with latency 1, result = 0, zero_flag = 1, other flags 0, illegal_op = 1.
REQ-031 illegal_op is 0 for every opcode when ALU_PIPE_MUL_EN is defined.

Structure
REQ-032 Package alu_pipe_pkg holds opcode enum (3-bit), FSM state enum (IDLE, MUL_RUN) and opcode constants.
REQ-033 Iterative multiplier is sub-module alu_pipe_mul (start, done, operands, 2*DATA_WIDTH product), instantiated only under ALU_PIPE_MUL_EN.

Verification (DATA_WIDTH = 8)
REQ-034 ADD 0x7F+0x01, out_ready=1 -> next cycle result 0x80, overflow 1, negative 1, carry 0, zero 0.
REQ-035 SUB 0x00-0x01 -> result 0xFF, carry 1, overflow 0, negative 1; SUB 0x05-0x05 -> result 0x00, zero 1.
REQ-036 SHL a=0x81 b=1 then SHR a=0x01 b=1 back-to-back -> results 0x02 carry 1, then 0x00 carry 1 zero 1, in_ready high throughout.
REQ-037 MUL 0x10*0x11 (MUL_EN) -> out_valid exactly 9 cycles after accept, result 0x10, overflow 1, in_ready low 8 cycles; without MUL_EN -> result 0x00, illegal_op 1, 1 cycle.
REQ-038 out_ready=0 for 5 cycles after ADD 0x03+0x04 -> result 0x07 held, in_ready 0, new in_valid not accepted; releases on out_ready=1.
REQ-039 rst pulse in 4th cycle of MUL 0xFF*0xFF -> outputs all 0 at once, no out_valid after release, next ADD 0x01+0x01 yields 0x02.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, FSM states and width limits.
package alu_pipe_pkg;

  localparam int OPCODE_W  = 3;
  localparam int MIN_WIDTH = 4;
  localparam int MAX_WIDTH = 64;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } opcode_e;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_e;

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Only instantiated by alu_pipe when ALU_PIPE_MUL_EN is defined.
module alu_pipe_mul
  import alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    ack,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic                    busy;
  logic [CW-1:0]           count;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [2*DATA_WIDTH-1:0] addend;

  // The final step is folded into the product output, so the consumer can
  // capture the full product on the same edge that ends the last step.
  assign addend  = mplier[0] ? mcand : '0;
  assign product = acc + addend;
  assign done    = busy && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= {{DATA_WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      if (count != LAST) begin
        acc    <= product;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
      end else if (ack) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready ALU with registered result and flags; single-cycle ops plus an
// optional iterative multiplier enabled by the ALU_PIPE_MUL_EN macro.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [OPCODE_W-1:0]   opcode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero_flag,
  output logic                  carry_flag,
  output logic                  overflow_flag,
  output logic                  negative_flag,
  output logic                  illegal_op
);

  localparam int SW = $clog2(DATA_WIDTH);

  state_e                op;
  state_e                state;
  logic                  accept;
  logic                  load_alu;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH:0]   shl_w;
  logic [DATA_WIDTH:0]   shr_w;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_carry;
  logic                  alu_ovf;
  logic                  alu_illegal;
  opcode_e               opc;

  assign opc      = opcode_e'(opcode);
  assign op       = state;
  assign in_ready = (op == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Shifts carry one guard bit so the last bit shifted out lands at a fixed index.
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shl_w = {1'b0, a} << b[SW-1:0];
  assign shr_w = {a, 1'b0} >> b[SW-1:0];

  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (opc)
      OP_ADD: begin
        alu_res   = sum[DATA_WIDTH-1:0];
        alu_carry = sum[DATA_WIDTH];
        alu_ovf   = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff[DATA_WIDTH-1:0];
        alu_carry = diff[DATA_WIDTH];
        alu_ovf   = (a[DATA_WIDTH-1] != b[DATA_WIDTH-1]) && (diff[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_SHL: begin
        alu_res   = shl_w[DATA_WIDTH-1:0];
        alu_carry = shl_w[DATA_WIDTH];
      end
      OP_SHR: begin
        alu_res   = shr_w[DATA_WIDTH:1];
        alu_carry = shr_w[0];
      end
      default: begin
`ifdef ALU_PIPE_MUL_EN
        alu_illegal = 1'b0;
`else
        alu_illegal = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  logic                    mul_start;
  logic                    mul_done;
  logic                    mul_take;
  logic [2*DATA_WIDTH-1:0] mul_product;

  assign mul_start = accept && (opc == OP_MUL);
  assign load_alu  = accept && (opc != OP_MUL);
  // Completion waits in the last step until any unconsumed result drains.
  assign mul_take  = (state == MUL_RUN) && mul_done && (!out_valid || out_ready);

  alu_pipe_mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .ack     (mul_take),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign load_alu = accept;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      result        <= '0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
      negative_flag <= 1'b0;
      illegal_op    <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (load_alu) begin
        out_valid     <= 1'b1;
        result        <= alu_res;
        zero_flag     <= (alu_res == '0);
        carry_flag    <= alu_carry;
        overflow_flag <= alu_ovf;
        negative_flag <= alu_res[DATA_WIDTH-1];
        illegal_op    <= alu_illegal;
      end
`ifdef ALU_PIPE_MUL_EN
      if (mul_start)
        state <= MUL_RUN;
      if (mul_take) begin
        state         <= IDLE;
        out_valid     <= 1'b1;
        result        <= mul_product[DATA_WIDTH-1:0];
        zero_flag     <= (mul_product[DATA_WIDTH-1:0] == '0);
        carry_flag    <= 1'b0;
        overflow_flag <= (mul_product[2*DATA_WIDTH-1:DATA_WIDTH] != '0);
        negative_flag <= mul_product[DATA_WIDTH-1];
        illegal_op    <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at DATA_WIDTH = 8; expectations follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       o;
    logic       n;
    logic       ill;
  } exp_t;

`ifdef ALU_PIPE_MUL_EN
  localparam int MUL_LAT  = 9;
  localparam int MUL_BUSY = 8;
  localparam bit ABORT_PUSH = 1'b0;
`else
  localparam int MUL_LAT  = 1;
  localparam int MUL_BUSY = 0;
  localparam bit ABORT_PUSH = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, result;
  logic [2:0] opcode;
  logic       zero_flag, carry_flag, overflow_flag, negative_flag, illegal_op;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  string name_q[$];
  exp_t mon_e;
  string mon_n;

  alu_pipe #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .overflow_flag(overflow_flag), .negative_flag(negative_flag), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] r, input logic z, c, o, n, ill);
    return '{res: r, z: z, c: c, o: o, n: n, ill: ill};
  endfunction

  function automatic exp_t mul_e(input exp_t e);
`ifdef ALU_PIPE_MUL_EN
    return e;
`else
    return mk(8'h00, 1, 0, 0, 0, 1);
`endif
  endfunction

  // Monitor: every completed output transfer is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_output", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        check_output({mon_n, ".result"},   result,        mon_e.res);
        check_output({mon_n, ".zero"},     zero_flag,     mon_e.z);
        check_output({mon_n, ".carry"},    carry_flag,    mon_e.c);
        check_output({mon_n, ".overflow"}, overflow_flag, mon_e.o);
        check_output({mon_n, ".negative"}, negative_flag, mon_e.n);
        check_output({mon_n, ".illegal"},  illegal_op,    mon_e.ill);
      end
    end
  end

  task automatic apply_stimulus(input string name, input logic [2:0] op, input logic [7:0] av,
                                input logic [7:0] bv, input exp_t e, input bit push,
                                output int waits, output int acc_cyc);
    bit got = 0;
    in_valid = 1'b1;
    opcode = op;
    a = av;
    b = bv;
    waits = 0;
    acc_cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
      waits++;
    end
    if (!got) begin
      check_output({name, ".accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back(e);
      name_q.push_back(name);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input int acc_cyc, input int lat_exp, input int busy_exp);
    int low = 0;
    bit seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1;
        break;
      end
      if (!in_ready) low++;
    end
    if (!seen) begin
      check_output({name, ".out_valid_timeout"}, 0, 1);
    end else begin
      check_output({name, ".latency"}, cyc - acc_cyc + 1, lat_exp);
      check_output({name, ".in_ready_low"}, low, busy_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] av,
                        input logic [7:0] bv, input exp_t e, input int lat, input int busy);
    int w, ac;
    apply_stimulus(name, op, av, bv, e, 1'b1, w, ac);
    wait_result(name, ac, lat, busy);
  endtask

  initial begin
    int w1, w2, ac, seen_valid;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    opcode = '0;
    out_ready = 1'b1;
    #12;
    check_output("reset.out_valid", out_valid, 0);
    check_output("reset.result", result, 0);
    check_output("reset.flags", {zero_flag, carry_flag, overflow_flag, negative_flag, illegal_op}, 0);
    check_output("reset.in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    apply_stimulus("add_7f_01", OP_ADD, 8'h7F, 8'h01, mk(8'h80, 0, 0, 1, 1, 0), 1'b1, w1, ac);
    check_output("first_accept_after_reset.waits", w1, 0);
    wait_result("add_7f_01", ac, 1, 0);

    run_op("sub_00_01", OP_SUB, 8'h00, 8'h01, mk(8'hFF, 0, 1, 0, 1, 0), 1, 0);
    run_op("sub_05_05", OP_SUB, 8'h05, 8'h05, mk(8'h00, 1, 0, 0, 0, 0), 1, 0);

    apply_stimulus("shl_81_1", OP_SHL, 8'h81, 8'h01, mk(8'h02, 0, 1, 0, 0, 0), 1'b1, w1, ac);
    apply_stimulus("shr_01_1", OP_SHR, 8'h01, 8'h01, mk(8'h00, 1, 1, 0, 0, 0), 1'b1, w2, ac);
    check_output("back_to_back.shl_waits", w1, 0);
    check_output("back_to_back.shr_waits", w2, 0);
    wait_result("shr_01_1", ac, 1, 0);

    run_op("and_f0_3c", OP_AND, 8'hF0, 8'h3C, mk(8'h30, 0, 0, 0, 0, 0), 1, 0);
    run_op("or_f0_0f",  OP_OR,  8'hF0, 8'h0F, mk(8'hFF, 0, 0, 0, 1, 0), 1, 0);
    run_op("xor_aa_ff", OP_XOR, 8'hAA, 8'hFF, mk(8'h55, 0, 0, 0, 0, 0), 1, 0);
    run_op("shl_03_7",  OP_SHL, 8'h03, 8'h07, mk(8'h80, 0, 1, 0, 1, 0), 1, 0);
    run_op("shr_80_7",  OP_SHR, 8'h80, 8'h07, mk(8'h01, 0, 0, 0, 0, 0), 1, 0);
    run_op("shl_81_0",  OP_SHL, 8'h81, 8'h08, mk(8'h81, 0, 0, 0, 1, 0), 1, 0);
    run_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, mk(8'h00, 1, 1, 0, 0, 0), 1, 0);
    run_op("add_ff_ff", OP_ADD, 8'hFF, 8'hFF, mk(8'hFE, 0, 1, 0, 1, 0), 1, 0);
    run_op("sub_80_01", OP_SUB, 8'h80, 8'h01, mk(8'h7F, 0, 0, 1, 0, 0), 1, 0);

    run_op("mul_10_11", OP_MUL, 8'h10, 8'h11, mul_e(mk(8'h10, 0, 0, 1, 0, 0)), MUL_LAT, MUL_BUSY);
    run_op("mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, mul_e(mk(8'h01, 0, 0, 1, 0, 0)), MUL_LAT, MUL_BUSY);
    run_op("mul_0f_0f", OP_MUL, 8'h0F, 8'h0F, mul_e(mk(8'hE1, 0, 0, 0, 1, 0)), MUL_LAT, MUL_BUSY);
    run_op("mul_00_ff", OP_MUL, 8'h00, 8'hFF, mul_e(mk(8'h00, 1, 0, 0, 0, 0)), MUL_LAT, MUL_BUSY);

    // Backpressure: result held and new bundle refused while out_ready is low.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    apply_stimulus("bp_add_03_04", OP_ADD, 8'h03, 8'h04, mk(8'h07, 0, 0, 0, 0, 0), 1'b1, w1, ac);
    in_valid = 1'b1;
    opcode = OP_ADD;
    a = 8'h01;
    b = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output($sformatf("bp_stall%0d.in_ready", i), in_ready, 0);
      check_output($sformatf("bp_stall%0d.out_valid", i), out_valid, 1);
      check_output($sformatf("bp_stall%0d.result", i), result, 8'h07);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    apply_stimulus("bp_add_01_02", OP_ADD, 8'h01, 8'h02, mk(8'h03, 0, 0, 0, 0, 0), 1'b1, w1, ac);
    check_output("bp_release.waits", w1, 0);
    wait_result("bp_add_01_02", ac, 1, 0);

    // Reset during an in-flight multiply.
    apply_stimulus("abort_mul_ff_ff", OP_MUL, 8'hFF, 8'hFF, mk(8'h00, 1, 0, 0, 0, 1), ABORT_PUSH, w1, ac);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_output("abort.out_valid", out_valid, 0);
    check_output("abort.result", result, 0);
    check_output("abort.flags", {zero_flag, carry_flag, overflow_flag, negative_flag, illegal_op}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check_output("abort.no_output_after_release", seen_valid, 0);
    check_output("abort.scoreboard_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
    run_op("post_abort_add_01_01", OP_ADD, 8'h01, 8'h01, mk(8'h02, 0, 0, 0, 0, 0), 1, 0);

    repeat (3) @(posedge clk);
    check_output("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
